// File: rtl/maze_pkg.sv
// Shared types for the maze loader: FSM states, error codes and the default maze size.
package maze_pkg;

  localparam int unsigned MAZE_SIZE = 9;

  typedef enum logic [1:0] {
    StLoad,
    StCheck,
    StReady,
    StError
  } maze_ld_state_t;

  typedef enum logic [2:0] {
    ErrNone   = 3'd0,
    ErrShort  = 3'd1,
    ErrNoLast = 3'd2,
    ErrTop    = 3'd3,
    ErrBottom = 3'd4,
    ErrSide   = 3'd5
  } maze_err_t;

endpackage

// File: rtl/maze_border_check.sv
// Sequential border walker: scans one index per cycle after a start pulse, counting openings
// in the top and bottom rows and looking for breaches in the side columns.
// Instantiated by maze_loader only when MAZE_LOADER_CHECK_EN is defined.
module maze_border_check
  import maze_pkg::*;
#(
  parameter int unsigned SIZE = MAZE_SIZE,
  parameter int unsigned RW   = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            start,
  input  logic [SIZE-1:0] maze [SIZE],
  output logic            done,
  output maze_err_t       code,
  output logic [RW-1:0]   start_col,
  output logic [RW-1:0]   exit_col
);

  localparam logic [RW-1:0] LastIdx = RW'(SIZE - 1);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [RW-1:0] idx_q, idx_d;
  logic [1:0]    top_cnt_q, top_cnt_d;
  logic [1:0]    bot_cnt_q, bot_cnt_d;
  logic          side_q, side_d;
  logic [RW-1:0] top_col_q, top_col_d;
  logic [RW-1:0] bot_col_q, bot_col_d;
  maze_err_t     code_q, code_d;
  logic          top_zero, bot_zero, side_hit;

  // Walk one index per cycle; zero counters saturate at 2 so "two or more" stays distinct.
  always_comb begin
    top_zero  = ~maze[0][idx_q];
    bot_zero  = ~maze[SIZE-1][idx_q];
    side_hit  = (idx_q != '0) && (idx_q != LastIdx) &&
                (~maze[idx_q][0] || ~maze[idx_q][SIZE-1]);
    busy_d    = busy_q;
    done_d    = done_q;
    idx_d     = idx_q;
    top_cnt_d = top_cnt_q;
    bot_cnt_d = bot_cnt_q;
    side_d    = side_q;
    top_col_d = top_col_q;
    bot_col_d = bot_col_q;
    code_d    = code_q;
    if (clr || start) begin
      busy_d    = start;
      done_d    = 1'b0;
      idx_d     = '0;
      top_cnt_d = '0;
      bot_cnt_d = '0;
      side_d    = 1'b0;
      top_col_d = '0;
      bot_col_d = '0;
      code_d    = ErrNone;
    end else if (busy_q) begin
      if (top_zero) begin
        if (top_cnt_q == 2'd0) top_col_d = idx_q;
        if (top_cnt_q != 2'd2) top_cnt_d = top_cnt_q + 2'd1;
      end
      if (bot_zero) begin
        if (bot_cnt_q == 2'd0) bot_col_d = idx_q;
        if (bot_cnt_q != 2'd2) bot_cnt_d = bot_cnt_q + 2'd1;
      end
      if (side_hit) side_d = 1'b1;
      if (idx_q == LastIdx) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        if (top_cnt_d != 2'd1)      code_d = ErrTop;
        else if (bot_cnt_d != 2'd1) code_d = ErrBottom;
        else if (side_d)            code_d = ErrSide;
        else                        code_d = ErrNone;
      end else begin
        idx_d = idx_q + RW'(1);
      end
    end
  end

  // Walker state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      top_cnt_q <= '0;
      bot_cnt_q <= '0;
      side_q    <= 1'b0;
      top_col_q <= '0;
      bot_col_q <= '0;
      code_q    <= ErrNone;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      idx_q     <= idx_d;
      top_cnt_q <= top_cnt_d;
      bot_cnt_q <= bot_cnt_d;
      side_q    <= side_d;
      top_col_q <= top_col_d;
      bot_col_q <= bot_col_d;
      code_q    <= code_d;
    end
  end

  assign done      = done_q;
  assign code      = code_q;
  assign start_col = top_col_q;
  assign exit_col  = bot_col_q;

endmodule

// File: rtl/maze_loader.sv
// Maze loader: assembles SIZE rows from a valid/ready stream into the wall array, optionally
// validates the border, then holds the maze with maze_valid high until reload or rst.
// Border checking is compiled in with MAZE_LOADER_CHECK_EN.
module maze_loader
  import maze_pkg::*;
#(
  parameter int unsigned SIZE = MAZE_SIZE,
  parameter int unsigned RW   = $clog2(SIZE)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] in_row,
  input  logic            in_last,
  input  logic            reload,
  output logic [SIZE-1:0] maze [SIZE],
  output logic            maze_valid,
  output logic            maze_err,
  output logic [2:0]      err_code,
  output logic [RW-1:0]   start_col,
  output logic [RW-1:0]   exit_col
);

  localparam logic [RW-1:0] LastRow = RW'(SIZE - 1);

  maze_ld_state_t  state_q, state_d;
  maze_err_t       err_code_q, code_d;
  logic [RW-1:0]   row_cnt_q;
  logic [SIZE-1:0] maze_q [SIZE];
  logic            maze_valid_q, maze_valid_d;
  logic            maze_err_q, maze_err_d;
  logic [RW-1:0]   start_col_q, start_col_d;
  logic [RW-1:0]   exit_col_q, exit_col_d;
  logic            accept, row_last, last_ok;

  // reload wins over any handshake in the same cycle
  assign accept   = in_valid && in_ready && !reload;
  assign row_last = (row_cnt_q == LastRow);
  assign last_ok  = accept && row_last && in_last;

`ifdef MAZE_LOADER_CHECK_EN
  logic      chk_done;
  maze_err_t chk_code;
  logic [RW-1:0] chk_start_col, chk_exit_col;

  assign in_ready = (state_q == StLoad);

  maze_border_check #(
    .SIZE (SIZE),
    .RW   (RW)
  ) u_border_check (
    .clk       (clk),
    .rst       (rst),
    .clr       (reload),
    .start     (last_ok),
    .maze      (maze_q),
    .done      (chk_done),
    .code      (chk_code),
    .start_col (chk_start_col),
    .exit_col  (chk_exit_col)
  );
`else
  // One-cycle gap between the last beat and READY.
  logic pend_q;

  assign in_ready = (state_q == StLoad) && !pend_q;
`endif

  // State and error-code register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StLoad;
      err_code_q <= ErrNone;
    end else begin
      state_q    <= state_d;
      err_code_q <= code_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    code_d  = err_code_q;
    if (reload) begin
      state_d = StLoad;
      code_d  = ErrNone;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (accept) begin
            if (in_last && !row_last) begin
              state_d = StError;
              code_d  = ErrShort;
            end else if (row_last && !in_last) begin
              state_d = StError;
              code_d  = ErrNoLast;
            end else if (row_last) begin
`ifdef MAZE_LOADER_CHECK_EN
              state_d = StCheck;
`endif
            end
          end
`ifndef MAZE_LOADER_CHECK_EN
          if (pend_q) state_d = StReady;
`endif
        end
        StCheck: begin
`ifdef MAZE_LOADER_CHECK_EN
          if (chk_done) begin
            state_d = (chk_code == ErrNone) ? StReady : StError;
            code_d  = chk_code;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Output logic: next values of the registered status outputs.
  always_comb begin
    maze_valid_d = (state_d == StReady);
    maze_err_d   = (state_d == StError);
    start_col_d  = start_col_q;
    exit_col_d   = exit_col_q;
    if (reload) begin
      start_col_d = '0;
      exit_col_d  = '0;
    end
`ifdef MAZE_LOADER_CHECK_EN
    else if ((state_q == StCheck) && chk_done) begin
      start_col_d = chk_start_col;
      exit_col_d  = chk_exit_col;
    end
`endif
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      maze_valid_q <= 1'b0;
      maze_err_q   <= 1'b0;
      start_col_q  <= '0;
      exit_col_q   <= '0;
    end else begin
      maze_valid_q <= maze_valid_d;
      maze_err_q   <= maze_err_d;
      start_col_q  <= start_col_d;
      exit_col_q   <= exit_col_d;
    end
  end

  // Row storage and counter; the array only changes on accepted beats, reset or reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q <= '0;
      maze_q    <= '{default: '1};
    end else if (reload) begin
      row_cnt_q <= '0;
      maze_q    <= '{default: '1};
    end else if (accept) begin
      maze_q[row_cnt_q] <= in_row;
      row_cnt_q         <= row_cnt_q + RW'(1);
    end
  end

`ifndef MAZE_LOADER_CHECK_EN
  // Marks the cycle after a correct last row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pend_q <= 1'b0;
    else if (reload) pend_q <= 1'b0;
    else             pend_q <= last_ok;
  end
`endif

  assign maze       = maze_q;
  assign maze_valid = maze_valid_q;
  assign maze_err   = maze_err_q;
  assign err_code   = err_code_q;
`ifdef MAZE_LOADER_CHECK_EN
  assign start_col  = start_col_q;
  assign exit_col   = exit_col_q;
`else
  assign start_col  = '0;
  assign exit_col   = '0;
`endif

endmodule

// File: doc/maze_loader.md
# maze_loader

Upstream stage of the maze solver: accepts a maze one row per beat over a valid/ready stream and assembles it into the SIZE×SIZE wall array the maze escaper consumes. Optionally validates the maze border, one entry opening in the top row and one exit opening in the bottom row. It then holds the array stable with `maze_valid` high, which the escaper stage uses as its release from reset.

## Interface
- `SIZE`, 9, maze edge length in cells; must be at least 3.
- `RW`, `$clog2(SIZE)`, width of the row and column indices.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  row beat valid.
- `in_ready`  out  1  loader can accept a row.
- `in_row`  in  SIZE  row data; bit c = column c; 1 = wall, 0 = open.
- `in_last`  in  1  marks the final row of the maze.
- `reload`  in  1  synchronous restart; discards the current maze.
- `maze`  out  SIZE×SIZE  unpacked array of packed rows, `maze[row][col]`.
- `maze_valid`  out  1  maze complete and accepted; `maze` is stable.
- `maze_err`  out  1  load or check failed.
- `err_code`  out  3  reason for failure; 0 = none.
- `start_col`  out  RW  column of the opening in row 0.
- `exit_col`  out  RW  column of the opening in row SIZE-1.

## Operation
- States are LOAD, CHECK, READY and ERROR.
- Reset and `reload` produce the same result:
  - state = LOAD; row counter = 0;
  - `maze` = all ones;
  - `maze_valid`, `maze_err`, `err_code`, `start_col`, `exit_col` = 0.
- `reload` overrides any handshake in the same cycle.
- `in_ready` = 1 only in LOAD.
- LOAD: a beat is accepted when `in_valid && in_ready`. On acceptance, `maze[row_cnt] <= in_row` and `row_cnt` increments.
  - `in_last` with row_cnt < SIZE-1 → ERROR, code 1 (SHORT).
  - Row SIZE-1 accepted without `in_last` → ERROR, code 2 (NO_LAST).
  - Row SIZE-1 accepted with `in_last` → CHECK, check index = 0.
- CHECK runs one index i per cycle, for i = 0..SIZE-1:
  - count zeros in `maze[0][i]` and record the first zero column in `start_col`;
  - likewise, count zeros in `maze[SIZE-1][i]` and record the first zero in `exit_col`;
  - for 1 ≤ i ≤ SIZE-2, flag a side breach if `maze[i][0]` or `maze[i][SIZE-1]` is 0.
- After i = SIZE-1, the result is evaluated with priority TOP > BOTTOM > SIDE:
  - top zero count ≠ 1 → code 3;
  - else bottom zero count ≠ 1 → code 4;
  - else side breach → code 5;
  - else READY.
- Zero counters saturate at 2.
- READY: `maze_valid` = 1. All further input is ignored (`in_ready` = 0) until `reload` or `rst`.
- ERROR: `maze_err` = 1 and `err_code` holds the reason. `in_ready` = 0 until `reload` or `rst`. The partial `maze` contents remain visible.

## Timing
- One row is accepted per cycle at full throughput; the minimum load time is SIZE cycles.
- The last row is accepted at edge E:
  - with checks compiled in, `maze_valid` or `maze_err` rises at edge E+SIZE+1;
  - without checks, READY is entered at edge E+1.
- Load errors (codes 1 and 2) rise at the edge that accepts the offending beat.
- All outputs are registered. `maze` changes only on accepted beats, reset or `reload`.
- `reload` asserted mid-load takes effect at the next edge. A beat presented in that same cycle is dropped.

## Configuration
- Macro: `MAZE_LOADER_CHECK_EN`.
- Defined: CHECK state, error codes 3–5, and `start_col`/`exit_col` all operate as described above.
- Undefined:
  - CHECK is removed; LOAD goes directly to READY on a correct last row;
  - `start_col` and `exit_col` are tied to 0;
  - only codes 1 and 2 can occur.

## Structure
- Package `maze_pkg` contains:
  - the state enum `maze_ld_state_t` (LOAD, CHECK, READY, ERROR);
  - the error enum `maze_err_t` (NONE=0, SHORT=1, NO_LAST=2, TOP=3, BOTTOM=4, SIDE=5);
  - the default `MAZE_SIZE` = 9.
- One sub-module, `maze_border_check`: the sequential CHECK walker. It has a start pulse and takes the array as input. It returns done, an error code, `start_col` and `exit_col`, and is instantiated only under `MAZE_LOADER_CHECK_EN`.

## Test plan
- Valid 9×9 maze streamed back-to-back with openings at top column 1 and bottom column 7 → `maze` equals the input, `maze_valid` = 1 at E+10, `start_col` = 1, `exit_col` = 7, `err_code` = 0.
- `in_last` on the 5th row → `maze_err` = 1 and `err_code` = 1 at that edge; `in_ready` = 0 afterwards.
- 9 rows with no `in_last` → `err_code` = 2; a further beat offered is not accepted.
- Top row all ones → `err_code` = 3. Two openings in both the top and bottom rows → `err_code` = 3 (priority rule).
- Row 4 with column 0 open → `err_code` = 5. Then `reload` followed by a valid maze → `maze_valid` = 1 and `err_code` = 0.
- `in_valid` toggled randomly during a load, with `rst` asserted after row 3 → all outputs return to reset values immediately, and `maze` = all ones.
